// File: rtl/aes_pkg.sv
// aes_pkg: types and constants shared by the AddRoundKey buffer stage.
//   AES_BLOCK_BYTES : bytes in one AES block / round key
//   aes_byte_t      : one byte of key or state
//   ark_state_e     : control states of the AddRoundKey buffer
package aes_pkg;

    localparam int unsigned AES_BLOCK_BYTES = 16;

    typedef logic [7:0] aes_byte_t;

    // One-hot so that any corrupted encoding is detectably invalid and
    // steered back to ST_LOAD by the default branch of the FSM.
    typedef enum logic [1:0] {
        ST_LOAD = 2'b01,
        ST_EMIT = 2'b10
    } ark_state_e;

endpackage

// File: rtl/byte_buf16.sv
// byte_buf16: DEPTH x 8 register file, one synchronous write port and one
// asynchronous read port. Contents are not reset.
//   clk   : clock, write on rising edge
//   we    : write enable
//   waddr : write address
//   wdata : write data byte
//   raddr : read address
//   rdata : read data byte (combinational from raddr)
module byte_buf16
    import aes_pkg::*;
#(
    parameter int unsigned DEPTH = AES_BLOCK_BYTES,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/add_round_key_buf.sv
// add_round_key_buf: collects one byte-serial round key and one byte-serial
// AES state (in any order, overlapping or with gaps), then streams out
// state[i] ^ key[i] for i = 0..NBYTES-1 as a contiguous burst.
//   clk, rst    : clock and synchronous active-high reset
//   key_in      : round-key byte,  key_valid   : key_in valid
//   state_in    : state byte,      state_valid : state_in valid
//   key_ready   : a key byte would be accepted this cycle
//   state_ready : a state byte would be accepted this cycle
//   dout        : AddRoundKey result byte, dout_valid : dout valid
//   busy        : high while the result burst is being emitted
//   ovf         : sticky, a valid byte was dropped (cleared by rst only)
// All outputs except the readies are registered; the readies depend only
// on registered state, so there is no input-to-output combinational path.
module add_round_key_buf
    import aes_pkg::*;
#(
    parameter int unsigned NBYTES = AES_BLOCK_BYTES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_in,
    input  logic       key_valid,
    input  logic [7:0] state_in,
    input  logic       state_valid,
    output logic       key_ready,
    output logic       state_ready,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       busy,
    output logic       ovf
);

    localparam int unsigned CW = $clog2(NBYTES) + 1;
    localparam int unsigned AW = $clog2(NBYTES);
    localparam logic [CW-1:0] CNT_FULL = CW'(NBYTES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    ark_state_e    state_q, state_d;
    logic [CW-1:0] key_cnt_q, key_cnt_d;
    logic [CW-1:0] st_cnt_q, st_cnt_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [7:0]    dout_d;
    logic          dout_valid_d;
    logic          busy_d;
    logic          ovf_d;

    logic          key_we, st_we;
    logic [AW-1:0] raddr;
    logic [7:0]    key_rd, st_rd;

    assign key_ready   = (state_q == ST_LOAD) && (key_cnt_q < CNT_FULL);
    assign state_ready = (state_q == ST_LOAD) && (st_cnt_q  < CNT_FULL);

    assign key_we = key_valid   && key_ready;
    assign st_we  = state_valid && state_ready;

    // In LOAD the read port presents byte 0 so the LOAD->EMIT edge can
    // register the first result; in EMIT it follows idx.
    assign raddr = (state_q == ST_EMIT) ? idx_q[AW-1:0] : '0;

    byte_buf16 #(
        .DEPTH (NBYTES),
        .AW    (AW)
    ) u_key_buf (
        .clk   (clk),
        .we    (key_we),
        .waddr (key_cnt_q[AW-1:0]),
        .wdata (key_in),
        .raddr (raddr),
        .rdata (key_rd)
    );

    byte_buf16 #(
        .DEPTH (NBYTES),
        .AW    (AW)
    ) u_state_buf (
        .clk   (clk),
        .we    (st_we),
        .waddr (st_cnt_q[AW-1:0]),
        .wdata (state_in),
        .raddr (raddr),
        .rdata (st_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            key_cnt_q  <= '0;
            st_cnt_q   <= '0;
            idx_q      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_cnt_q  <= key_cnt_d;
            st_cnt_q   <= st_cnt_d;
            idx_q      <= idx_d;
            dout       <= dout_d;
            dout_valid <= dout_valid_d;
            busy       <= busy_d;
            ovf        <= ovf_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        key_cnt_d    = key_cnt_q;
        st_cnt_d     = st_cnt_q;
        idx_d        = idx_q;
        dout_d       = dout;
        dout_valid_d = dout_valid;
        busy_d       = busy;
        // Any valid byte offered while its ready is low is lost.
        ovf_d        = ovf
                     | (key_valid   & ~key_ready)
                     | (state_valid & ~state_ready);

        case (state_q)
            ST_LOAD: begin
                if (key_we) begin
                    key_cnt_d = key_cnt_q + CNT_ONE;
                end
                if (st_we) begin
                    st_cnt_d = st_cnt_q + CNT_ONE;
                end
                // Uses registered counts: the last captured byte is visible
                // one edge later, when the first result is registered.
                if ((key_cnt_q == CNT_FULL) && (st_cnt_q == CNT_FULL)) begin
                    dout_d       = st_rd ^ key_rd;
                    dout_valid_d = 1'b1;
                    busy_d       = 1'b1;
                    idx_d        = CNT_ONE;
                    state_d      = ST_EMIT;
                end
            end

            ST_EMIT: begin
                if (idx_q < CNT_FULL) begin
                    dout_d = st_rd ^ key_rd;
                    idx_d  = idx_q + CNT_ONE;
                end else begin
                    // dout keeps the last byte after the burst ends.
                    dout_valid_d = 1'b0;
                    busy_d       = 1'b0;
                    key_cnt_d    = '0;
                    st_cnt_d     = '0;
                    idx_d        = '0;
                    state_d      = ST_LOAD;
                end
            end

            default: begin
                state_d      = ST_LOAD;
                key_cnt_d    = '0;
                st_cnt_d     = '0;
                idx_d        = '0;
                dout_valid_d = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_add_round_key_buf.sv
module tb_add_round_key_buf;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] key_in;
    logic       key_valid;
    logic [7:0] state_in;
    logic       state_valid;
    logic       key_ready;
    logic       state_ready;
    logic [7:0] dout;
    logic       dout_valid;
    logic       busy;
    logic       ovf;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: the block currently being sent and the expected
    // AddRoundKey result, plus the expected sticky overflow flag.
    logic [7:0] kb    [16];
    logic [7:0] sb    [16];
    logic [7:0] exp_b [16];
    logic       exp_ovf;

    always #5 clk = ~clk;

    add_round_key_buf #(
        .NBYTES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .key_valid   (key_valid),
        .state_in    (state_in),
        .state_valid (state_valid),
        .key_ready   (key_ready),
        .state_ready (state_ready),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .busy        (busy),
        .ovf         (ovf)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_block();
        for (int i = 0; i < 16; i++) exp_b[i] = sb[i] ^ kb[i];
    endtask

    task automatic random_block();
        for (int i = 0; i < 16; i++) begin
            kb[i] = 8'($urandom);
            sb[i] = 8'($urandom);
        end
    endtask

    task automatic send_state();
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (state_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL state_ready byte %0d: got %b, required 1", i, state_ready);
            end
            state_valid = 1'b1;
            state_in    = sb[i];
            step();
            vectors++;
            if (dout_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL early_out state byte %0d: dout_valid=%b, required 0", i, dout_valid);
            end
        end
        state_valid = 1'b0;
    endtask

    task automatic send_key();
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (key_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL key_ready byte %0d: got %b, required 1", i, key_ready);
            end
            key_valid = 1'b1;
            key_in    = kb[i];
            step();
            vectors++;
            if (dout_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL early_out key byte %0d: dout_valid=%b, required 0", i, dout_valid);
            end
        end
        key_valid = 1'b0;
    endtask

    // Key and state streams each with independent random 0-3 cycle gaps.
    task automatic send_interleaved();
        int kp = 0;
        int sp = 0;
        int kg = int'($urandom_range(0, 3));
        int sg = int'($urandom_range(0, 3));
        while (kp < 16 || sp < 16) begin
            key_valid   = 1'b0;
            state_valid = 1'b0;
            if (kp < 16) begin
                if (kg == 0) begin
                    key_valid = 1'b1;
                    key_in    = kb[kp];
                    kp++;
                    kg = int'($urandom_range(0, 3));
                end else kg--;
            end
            if (sp < 16) begin
                if (sg == 0) begin
                    state_valid = 1'b1;
                    state_in    = sb[sp];
                    sp++;
                    sg = int'($urandom_range(0, 3));
                end else sg--;
            end
            step();
            vectors++;
            if (dout_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL early_out interleaved: dout_valid=%b busy=%b, required 0 0", dout_valid, busy);
            end
        end
        key_valid   = 1'b0;
        state_valid = 1'b0;
    endtask

    // Observe n output bytes, the first one edge after the last input byte.
    // inject >= 0 offers a state byte during that output cycle.
    task automatic collect(input int n, input int inject, input bit check_tail);
        for (int i = 0; i < n; i++) begin
            if (i == inject) begin
                vectors++;
                if (state_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL state_ready_emit: got %b, required 0", state_ready);
                end
                state_valid = 1'b1;
                state_in    = 8'($urandom);
                exp_ovf     = 1'b1;
            end
            step();
            state_valid = 1'b0;
            vectors++;
            if (dout_valid !== 1'b1 || busy !== 1'b1 || dout !== exp_b[i]) begin
                miscompares++;
                $display("FAIL out_byte %0d: dout=%h valid=%b busy=%b, required dout=%h valid=1 busy=1",
                         i, dout, dout_valid, busy, exp_b[i]);
            end
            vectors++;
            if (ovf !== exp_ovf) begin
                miscompares++;
                $display("FAIL ovf out_byte %0d: got %b, required %b", i, ovf, exp_ovf);
            end
        end
        if (check_tail) begin
            step();
            vectors++;
            if (dout_valid !== 1'b0 || busy !== 1'b0 || dout !== exp_b[n-1]) begin
                miscompares++;
                $display("FAIL out_tail: dout=%h valid=%b busy=%b, required dout=%h valid=0 busy=0",
                         dout, dout_valid, busy, exp_b[n-1]);
            end
            vectors++;
            if (key_ready !== 1'b1 || state_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL ready_after_emit: key_ready=%b state_ready=%b, required 1 1",
                         key_ready, state_ready);
            end
        end
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        key_valid   = 1'b1;
        key_in      = 8'($urandom);
        state_valid = 1'b1;
        state_in    = 8'($urandom);
        step();
        step();
        key_valid   = 1'b0;
        state_valid = 1'b0;
        rst         = 1'b0;
        exp_ovf     = 1'b0;
        vectors++;
        if (dout !== 8'h00 || dout_valid !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: dout=%h valid=%b busy=%b ovf=%b, required 00 0 0 0",
                     dout, dout_valid, busy, ovf);
        end
        vectors++;
        if (key_ready !== 1'b1 || state_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: key_ready=%b state_ready=%b, required 1 1", key_ready, state_ready);
        end
    endtask

    task automatic test_fips_round0();
        logic [127:0] sv = 128'h00112233445566778899aabbccddeeff;
        logic [127:0] kv = 128'h000102030405060708090a0b0c0d0e0f;
        logic [127:0] ev = 128'h00102030405060708090a0b0c0d0e0f0;
        for (int i = 0; i < 16; i++) begin
            sb[i]    = sv[127-8*i -: 8];
            kb[i]    = kv[127-8*i -: 8];
            exp_b[i] = ev[127-8*i -: 8];
        end
        send_state();
        send_key();
        collect(16, -1, 1'b1);
    endtask

    task automatic test_interleaved();
        for (int r = 0; r < 3; r++) begin
            random_block();
            model_block();
            send_interleaved();
            collect(16, -1, 1'b1);
        end
    endtask

    task automatic test_overflow();
        random_block();
        model_block();
        send_key();
        vectors++;
        if (key_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL key_ready_full: got %b, required 0", key_ready);
        end
        key_valid = 1'b1;
        key_in    = 8'hAA;
        step();
        key_valid = 1'b0;
        exp_ovf   = 1'b1;
        vectors++;
        if (ovf !== 1'b1 || key_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_17th_key: ovf=%b key_ready=%b, required 1 0", ovf, key_ready);
        end
        send_state();
        collect(16, 5, 1'b1);
        rst = 1'b1;
        step();
        rst     = 1'b0;
        exp_ovf = 1'b0;
        vectors++;
        if (ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear_by_rst: got %b, required 0", ovf);
        end
    endtask

    task automatic test_back_to_back();
        random_block();
        model_block();
        send_interleaved();
        collect(16, -1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            kb[i] = 8'hFF;
            sb[i] = 8'h5A;
        end
        model_block();
        send_key();
        send_state();
        collect(16, -1, 1'b1);
    endtask

    task automatic test_reset_mid();
        random_block();
        model_block();
        send_state();
        send_key();
        collect(8, -1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if (dout_valid !== 1'b0 || dout !== 8'h00 || busy !== 1'b0 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: dout=%h valid=%b busy=%b ovf=%b, required 00 0 0 0",
                     dout, dout_valid, busy, ovf);
        end
        vectors++;
        if (key_ready !== 1'b1 || state_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_ready: key_ready=%b state_ready=%b, required 1 1", key_ready, state_ready);
        end
        for (int i = 0; i < 16; i++) begin
            sb[i] = 8'h00;
            kb[i] = 8'h3C;
        end
        model_block();
        send_state();
        send_key();
        collect(16, -1, 1'b1);
    endtask

    initial begin
        rst         = 1'b1;
        key_in      = 8'h00;
        key_valid   = 1'b0;
        state_in    = 8'h00;
        state_valid = 1'b0;
        exp_ovf     = 1'b0;
        test_reset();
        test_fips_round0();
        test_interleaved();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
